seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
- Reverse of the team's hex-to-7-segment decoder. Monitors a multiplexed, common-anode 7-segment display bus and recovers the displayed hex digits.
- Inputs are active-low segments gfedcba plus active-low one-hot digit enables.
- Deglitches each digit slot, maps patterns back to nibbles and flags invalid ones.
- Delivers a complete multi-digit frame over a valid/ready interface. Used for display loopback checking and for scraping legacy front panels.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8).
- STABLE_CYC, 4, extra consecutive identical synchronized samples needed to accept a digit (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_n  input  7  segment lines, active-low, bit6=g .. bit0=a. Asynchronous to clk.
- an_n  input  NDIG  digit enables, active-low, bit0 = digit 0. Asynchronous to clk.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts frame.
- out_value  output  4*NDIG  digit k in bits [4k+3:4k].
- out_err  output  NDIG  bit k=1: digit k pattern was invalid.
- out_ovf  output  1  sticky: at least one completed frame dropped while out_valid was held.

Behaviour:
- Reset (async, immediate):
  - Synchronizers and previous-sample register = all ones.
  - Stability counter = 0, capture mask = 0, digit and error registers = 0.
  - out_valid=0, out_value=0, out_err=0, out_ovf=0.
- Synchronization: 2-flop synchronizer on {an_n, seg_n}. Only stage-2 values are used.
- Stability counter, per cycle:
  - s2 != prev: counter <= 0.
  - Otherwise: counter increments, saturating at STABLE_CYC.
  - prev <= s2 every cycle.
- Capture strobe: s2 == prev, counter == STABLE_CYC-1, and an_n in s2 has exactly one bit low.
  - The strobe fires once per stable period, on the (STABLE_CYC+1)-th consecutive identical sample.
  - Zero or multiple low enable bits never capture.
- Decode table (seg_n hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
  - Every other pattern, including blank 7F, is invalid: nibble 0, error bit 1.
- On capture of digit k: write nibble and error bit, set mask bit k. A digit recaptured before frame completion is overwritten with the latest value.
- Frame completion: the capture that makes the mask all ones. On that same edge the mask clears to 0.
- Output FSM, two states (EMPTY, FULL):
  - EMPTY: completion loads out_value/out_err from the digit registers including the completing digit, sets out_valid=1, goes to FULL.
  - FULL: out_value/out_err are held stable.
  - FULL, handshake (out_valid & out_ready): clears out_ovf. With a completion on the same edge, loads the new frame and stays FULL. Without one, goes to EMPTY with out_valid=0.
  - FULL, completion without handshake: new frame is dropped, out_ovf <= 1, output unchanged.
- Latency: a pin change reaches s2 after 2 edges. Capture occurs STABLE_CYC+1 s2 samples later. out_valid rises on the edge that captures the last missing digit.
- Scan order is irrelevant; any sequence covering all digits completes a frame.
- Reset mid-frame discards the partial mask and any pending output.

Test Plan:
1. Reset -> out_valid=0, out_value=0, out_err=0, out_ovf=0. Hold seg_n=7F, an_n=all ones for 20 cycles -> no capture.
2. NDIG=4, STABLE_CYC=4. Drive an_n=1110/1101/1011/0111 with seg_n=12/40/0E/19, 8 cycles each, out_ready=1 -> one out_valid pulse, out_value=0x4F05, out_err=0000, 1-cycle pulse as consumed.
3. Same scan, but digit 1 held only 3 cycles -> no frame. Re-scan digit 1 for 8 cycles -> frame 0x4F05 completes.
4. Digit 2 driven seg_n=7F, others as scenario 2 -> out_value=0x4005, out_err=0100.
5. out_ready=0, two full scans (second with 0x30 on digit 0) -> out_value stays 0x4F05, out_ovf=1. Pulse out_ready -> out_valid=0, out_ovf=0 next cycle.
6. an_n=1100 held 10 cycles -> no mask change. Mid-frame async rst pulse (not clock-aligned) -> all outputs 0 immediately; the next full scan produces a correct frame.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Watches a multiplexed common-anode 7-segment bus (active-low segments and
// digit enables), deglitches each digit slot, decodes the segment pattern back
// to a hex nibble and delivers complete NDIG-digit frames over valid/ready.
module seg7_scan_reader #(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          seg_n,
   input  logic [NDIG-1:0]     an_n,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*NDIG-1:0]   out_value,
   output logic [NDIG-1:0]     out_err,
   output logic                out_ovf
);

   localparam int W  = NDIG + 7;
   localparam int CW = $clog2(STABLE_CYC + 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   logic [W-1:0]      sync1_reg;
   logic [W-1:0]      sync2_reg;
   logic [W-1:0]      prev_reg;
   logic [CW-1:0]     cnt_reg;
   logic [NDIG-1:0]   mask_reg;
   logic [3:0]        digit_reg [NDIG];
   logic [NDIG-1:0]   err_reg;
   logic [4*NDIG-1:0] out_value_reg;
   logic [NDIG-1:0]   out_err_reg;
   logic              ovf_reg;
   state_t            state_reg;

   logic [6:0]        seg_s2;
   logic [NDIG-1:0]   an_s2;
   logic              same;
   logic              strobe;
   logic [NDIG-1:0]   cap_sel;
   logic [NDIG-1:0]   mask_set;
   logic              complete;
   logic [3:0]        nib;
   logic              nib_err;
   logic [4*NDIG-1:0] frame_value;
   logic [NDIG-1:0]   frame_err;
   state_t            state_next;
   logic              load_out;
   logic              ovf_next;

   assign seg_s2 = sync2_reg[6:0];
   assign an_s2  = sync2_reg[W-1:7];
   assign same   = (sync2_reg == prev_reg);

   // Capture once per stable period, only when exactly one digit is enabled.
   assign strobe   = same && (cnt_reg == CW'(STABLE_CYC - 1)) && $onehot(~an_s2);
   assign cap_sel  = strobe ? ~an_s2 : '0;
   assign mask_set = mask_reg | cap_sel;
   assign complete = strobe && (&mask_set);

   // Two-flop synchronizer on the whole bus plus the previous-sample register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= '1;
         sync2_reg <= '1;
         prev_reg  <= '1;
      end else begin
         sync1_reg <= {an_n, seg_n};
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   // Stability counter: restarts on any change, saturates at STABLE_CYC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (!same) begin
         cnt_reg <= '0;
      end else if (cnt_reg != CW'(STABLE_CYC)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Map a segment pattern back to its hex nibble; anything else is invalid.
   always_comb begin
      nib     = 4'h0;
      nib_err = 1'b0;
      case (seg_s2)
         7'h40: nib = 4'h0;
         7'h79: nib = 4'h1;
         7'h24: nib = 4'h2;
         7'h30: nib = 4'h3;
         7'h19: nib = 4'h4;
         7'h12: nib = 4'h5;
         7'h02: nib = 4'h6;
         7'h78: nib = 4'h7;
         7'h00: nib = 4'h8;
         7'h10: nib = 4'h9;
         7'h08: nib = 4'hA;
         7'h03: nib = 4'hB;
         7'h46: nib = 4'hC;
         7'h21: nib = 4'hD;
         7'h06: nib = 4'hE;
         7'h0E: nib = 4'hF;
         default: nib_err = 1'b1;
      endcase
   end

   // Capture mask: accumulate digits, clear on the completing capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_reg <= '0;
      end else if (complete) begin
         mask_reg <= '0;
      end else begin
         mask_reg <= mask_set;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_digit
         // Per-digit nibble/error storage; a recapture overwrites.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               digit_reg[gi] <= 4'h0;
               err_reg[gi]   <= 1'b0;
            end else if (cap_sel[gi]) begin
               digit_reg[gi] <= nib;
               err_reg[gi]   <= nib_err;
            end
         end

         // Frame view including the digit being captured this cycle.
         assign frame_value[4*gi +: 4] = cap_sel[gi] ? nib : digit_reg[gi];
         assign frame_err[gi]          = cap_sel[gi] ? nib_err : err_reg[gi];
      end
   endgenerate

   // Output FSM state and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= EMPTY;
         out_value_reg <= '0;
         out_err_reg   <= '0;
         ovf_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         ovf_reg   <= ovf_next;
         if (load_out) begin
            out_value_reg <= frame_value;
            out_err_reg   <= frame_err;
         end
      end
   end

   // Output FSM next-state: load on completion, drop and flag when still held.
   always_comb begin
      state_next = state_reg;
      load_out   = 1'b0;
      ovf_next   = ovf_reg;
      case (state_reg)
         EMPTY: begin
            if (complete) begin
               load_out   = 1'b1;
               state_next = FULL;
            end
         end
         FULL: begin
            if (out_ready) begin
               ovf_next = 1'b0;
               if (complete) begin
                  load_out = 1'b1;
               end else begin
                  state_next = EMPTY;
               end
            end else if (complete) begin
               ovf_next = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   assign out_valid = (state_reg == FULL);
   assign out_value = out_value_reg;
   assign out_err   = out_err_reg;
   assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NDIG=4, STABLE_CYC=4).
module tb_seg7_scan_reader;

   logic        clk;
   logic        rst;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_value;
   logic [3:0]  out_err;
   logic        out_ovf;

   int checks;
   int failures;
   int vcount;
   logic [15:0] last_val;
   logic [3:0]  last_err;

   seg7_scan_reader #(.NDIG(4), .STABLE_CYC(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_n     (seg_n),
      .an_n      (an_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_err   (out_err),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold one bus state for n cycles, recording any out_valid cycles seen.
   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_n  = an;
      seg_n = seg;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            vcount++;
            last_val = out_value;
            last_err = out_err;
         end
      end
   endtask

   task automatic idle();
      drive(4'b1111, 7'h7F, 4);
   endtask

   // Full scan digit 0..3, 8 cycles each, then blank.
   task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
      drive(4'b1110, s0, 8);
      drive(4'b1101, s1, 8);
      drive(4'b1011, s2, 8);
      drive(4'b0111, s3, 8);
      idle();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      vcount    = 0;
      last_val  = '0;
      last_err  = '0;
      rst       = 1'b1;
      seg_n     = 7'h7F;
      an_n      = 4'b1111;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // 1: reset state, idle bus never captures
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_value", 32'(out_value), 32'h0);
      check("rst_err",   32'(out_err),   32'h0);
      check("rst_ovf",   32'(out_ovf),   32'd0);
      rst = 1'b0;
      drive(4'b1111, 7'h7F, 20);
      check("idle_nocap", 32'(vcount), 32'd0);
      $display("txn idle: pulses=%0d", vcount);

      // 2: basic scan -> 0x4F05, single-cycle pulse
      vcount = 0;
      scan(7'h12, 7'h40, 7'h0E, 7'h19);
      check("s2_pulses", 32'(vcount), 32'd1);
      check("s2_value",  32'(last_val), 32'h4F05);
      check("s2_err",    32'(last_err), 32'h0);
      check("s2_valid_after", 32'(out_valid), 32'd0);
      $display("txn scan: pulses=%0d value=%h err=%b", vcount, last_val, last_err);

      // 3: short dwell on digit 1 does not capture; rescan completes
      vcount = 0;
      drive(4'b1110, 7'h12, 8);
      drive(4'b1101, 7'h40, 3);
      drive(4'b1011, 7'h0E, 8);
      drive(4'b0111, 7'h19, 8);
      idle();
      check("s3_short_noframe", 32'(vcount), 32'd0);
      drive(4'b1101, 7'h40, 8);
      idle();
      check("s3_pulses", 32'(vcount), 32'd1);
      check("s3_value",  32'(last_val), 32'h4F05);
      $display("txn rescan: pulses=%0d value=%h", vcount, last_val);

      // 4: blank digit 2 is invalid
      vcount = 0;
      scan(7'h12, 7'h40, 7'h7F, 7'h19);
      check("s4_pulses", 32'(vcount), 32'd1);
      check("s4_value",  32'(last_val), 32'h4005);
      check("s4_err",    32'(last_err), 32'b0100);
      $display("txn blank: value=%h err=%b", last_val, last_err);

      // 5: backpressure, second frame dropped, overflow sticky until handshake
      out_ready = 1'b0;
      scan(7'h12, 7'h40, 7'h0E, 7'h19);
      check("s5_valid1", 32'(out_valid), 32'd1);
      check("s5_value1", 32'(out_value), 32'h4F05);
      check("s5_ovf1",   32'(out_ovf),   32'd0);
      scan(7'h30, 7'h40, 7'h0E, 7'h19);
      check("s5_valid2", 32'(out_valid), 32'd1);
      check("s5_value2", 32'(out_value), 32'h4F05);
      check("s5_ovf2",   32'(out_ovf),   32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("s5_valid_clr", 32'(out_valid), 32'd0);
      check("s5_ovf_clr",   32'(out_ovf),   32'd0);
      $display("txn backpressure: value=%h ovf_cleared=%0d", out_value, !out_ovf);

      // 6a: two enables low never capture
      vcount = 0;
      drive(4'b1110, 7'h12, 8);
      drive(4'b1101, 7'h40, 8);
      drive(4'b1011, 7'h0E, 8);
      drive(4'b1100, 7'h00, 10);
      check("s6_multi_nocap", 32'(vcount), 32'd0);
      drive(4'b0111, 7'h19, 8);
      idle();
      check("s6_pulses", 32'(vcount), 32'd1);
      check("s6_value",  32'(last_val), 32'h4F05);
      $display("txn multi_enable: value=%h", last_val);

      // 6b: async reset mid-frame with a pending frame and overflow set
      out_ready = 1'b0;
      scan(7'h12, 7'h40, 7'h0E, 7'h19);
      scan(7'h12, 7'h40, 7'h0E, 7'h19);
      drive(4'b1110, 7'h12, 8);
      drive(4'b1101, 7'h40, 8);
      check("s6_pre_valid", 32'(out_valid), 32'd1);
      check("s6_pre_ovf",   32'(out_ovf),   32'd1);
      #2 rst = 1'b1;
      #1;
      check("s6_arst_valid", 32'(out_valid), 32'd0);
      check("s6_arst_value", 32'(out_value), 32'h0);
      check("s6_arst_err",   32'(out_err),   32'h0);
      check("s6_arst_ovf",   32'(out_ovf),   32'd0);
      an_n  = 4'b1111;
      seg_n = 7'h7F;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      vcount    = 0;
      drive(4'b1011, 7'h0E, 8);
      drive(4'b0111, 7'h19, 8);
      idle();
      check("s6_partial_discarded", 32'(vcount), 32'd0);
      scan(7'h12, 7'h40, 7'h0E, 7'h19);
      check("s6_post_pulses", 32'(vcount), 32'd1);
      check("s6_post_value",  32'(last_val), 32'h4F05);
      check("s6_post_err",    32'(last_err), 32'h0);
      $display("txn after_reset: value=%h err=%b", last_val, last_err);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
